blink_checker: RTL and testbench
================================

# blink_checker

Receive-side monitor for the blinker's `led`/`flg` output pair. It samples both signals in the blinker's clock domain and verifies two things: the `flg` pulse spacing equals the expected period, and `led` toggles exactly once per period, one cycle after `flg`. It reports lock, a sticky error with its cause, the last measured period and a blink count. It sits beside the blinker as an on-chip self-check and as a reusable bench monitor.

## Interface
- `CBITS`, 13, blinker counter width; expected period P = 2^CBITS cycles between `flg` pulses
- `TOL`, 0, accepted period deviation in cycles; TOL < P required
- `BW`, 16, width of the blink counter
- `clk`  in  1  clock; same clock as the blinker, no synchronizer
- `rst`  in  1  reset, asynchronous, active-high
- `led_in`  in  1  blinker `led`
- `flg_in`  in  1  blinker `flg`
- `locked`  out  1  high while in LOCK
- `err`  out  1  sticky error, high while in FAIL
- `err_code`  out  2  first error cause: 0 none, 1 period, 2 missing toggle, 3 spurious toggle
- `last_period`  out  CBITS+1  gap measured at the most recent `flg` after the first
- `blinks`  out  BW  count of valid `led` toggles; wraps mod 2^BW

## Operation
- All outputs and state are registered. Reset clears every output to 0 and the FSM goes to IDLE.
- Gap counter `gcnt` is CBITS+1 bits wide and saturates at all-ones.
  - On a cycle with `flg_in`=1: `gcnt` reloads to 1.
  - Otherwise: `gcnt` increments.
  - At a `flg` cycle, the measured period is the pre-reload `gcnt`.
- `led_prev` holds `led_in` from the previous cycle. `pend` is set in a `flg` cycle and cleared the next cycle.
- Toggle rules, active in ACQ and LOCK:
  - In the cycle after a `flg`, `led_in` ≠ `led_prev` is a valid toggle and increments `blinks`.
  - In that cycle, no change raises err 2.
  - A change in any other cycle raises err 3.
- Period rule, active in ACQ and LOCK:
  - At `flg`: if |gcnt−P| > TOL, raise err 1.
  - Timeout: if `gcnt` reaches P+TOL+1 without a `flg`, raise err 1.
- FSM:
  - IDLE: no checks. First `flg_in`=1 goes to ACQ; `gcnt` loads 1, `pend` sets.
  - ACQ: a `flg` with a good period and no error this cycle goes to LOCK and loads `last_period`.
  - LOCK: stays in LOCK; every `flg` updates `last_period`.
  - Any error in ACQ or LOCK goes to FAIL and latches `err_code`.
  - FAIL: terminal until `rst`. Counters freeze. `last_period` holds the value from the failing `flg` if there was one.
- Priority when several errors occur in one cycle: 1 > 2 > 3.
- A back-to-back `flg` (gap 1) is err 1. It takes priority over the toggle check in that cycle.

## Timing
- An event sampled at edge k becomes visible on outputs after edge k, i.e. in cycle k+1.
- With an ideal blinker, `locked` rises one cycle after the second `flg` sample. That is P+1 cycles after the first `flg` sample.
- `blinks` updates one cycle after the toggle cycle, which is two cycles after `flg`.
- Timeout: `err` rises one cycle after the sample where `gcnt` = P+TOL+1.
- `rst` asserted mid-operation clears all outputs immediately (asynchronous). The first sampled `flg` after release restarts acquisition.
- `led_in` level at reset release is don't-care.

## Test plan
- Ideal stream, CBITS=4, TOL=0: `flg` every 16 cycles, `led` toggling the cycle after each → `locked`=1 after the second `flg`, `last_period`=16, `err`=0; after 5 pulses `blinks`=5.
- Early `flg` at gap 15 while in LOCK → `err`=1, `err_code`=1, `locked`=0, `last_period`=15, `blinks` frozen.
- `flg` withheld after lock → `err`=1, `err_code`=1 exactly one cycle after the `gcnt`=17 sample.
- `led` does not toggle after a `flg` in ACQ → `err_code`=2, `locked` never asserts. With TOL=1, gaps of 15 and 17 are accepted.
- Single-cycle `led` glitch mid-period, plus a same-cycle period and toggle fault → `err_code`=3 for the glitch alone; `err_code`=1 when both faults coincide.
- `rst` pulse while in LOCK with `blinks`=7 → all outputs 0 during reset; the ideal stream then relocks and `blinks` restarts from 0.

Source files
------------

// File: rtl/blink_checker.sv
// blink_checker: watches the blinker's flg spacing and led toggle placement; reports lock, first error, period, count.
// Latency: every output reflects the sample taken at the previous clk edge; pure monitor, no backpressure.
module blink_checker #(
    parameter int CBITS = 13,
    parameter int TOL   = 0,
    parameter int BW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led_in,
    input  logic             flg_in,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CBITS:0]   last_period,
    output logic [BW-1:0]    blinks
);

    localparam int P       = 1 << CBITS;
    localparam int LIM_RAW = P + TOL + 1;
    // A timeout limit beyond the saturation value would never fire, so clamp it.
    localparam int LIM     = (LIM_RAW > 2 * P - 1) ? 2 * P - 1 : LIM_RAW;

    localparam logic [CBITS:0] PER    = (CBITS + 1)'(P);
    localparam logic [CBITS:0] TOLV   = (CBITS + 1)'(TOL);
    localparam logic [CBITS:0] TO_LIM = (CBITS + 1)'(LIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t         state;
    logic [CBITS:0] gcnt;
    logic           led_prev;
    logic           pend;

    logic [CBITS:0] dev;
    logic           toggled;
    logic           e_period;
    logic           e_missing;
    logic           e_spurious;
    logic [1:0]     code;

    always_comb begin
        dev        = (gcnt >= PER) ? (gcnt - PER) : (PER - gcnt);
        toggled    = (led_in != led_prev);
        e_period   = flg_in ? (dev > TOLV) : (gcnt >= TO_LIM);
        e_missing  = pend && !toggled;
        e_spurious = !pend && toggled;
        code       = 2'd0;
        if (e_period) begin
            code = 2'd1;
        end else if (e_missing) begin
            code = 2'd2;
        end else if (e_spurious) begin
            code = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gcnt        <= '0;
            led_prev    <= 1'b0;
            pend        <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
            last_period <= '0;
            blinks      <= '0;
        end else begin
            led_prev <= led_in;
            if (state != FAIL) begin
                pend <= flg_in;
                if (flg_in) begin
                    gcnt <= (CBITS + 1)'(1);
                end else if (gcnt != '1) begin
                    gcnt <= gcnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (flg_in) begin
                        state <= ACQ;
                    end
                end
                ACQ, LOCK: begin
                    if (code != 2'd0) begin
                        state    <= FAIL;
                        err      <= 1'b1;
                        err_code <= code;
                        locked   <= 1'b0;
                        if (flg_in) begin
                            last_period <= gcnt;
                        end
                    end else begin
                        // With no error, pend implies the led did toggle this cycle.
                        if (pend) begin
                            blinks <= blinks + 1'b1;
                        end
                        if (flg_in) begin
                            state       <= LOCK;
                            locked      <= 1'b1;
                            last_period <= gcnt;
                        end
                    end
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_checker.sv
// Bench for blink_checker: two instances (TOL=0 and TOL=1) fed the same led/flg stream, checked against a timestamp model.
module tb_blink_checker;

    localparam int CB = 4;
    localparam int P  = 16;
    localparam int BW = 16;
    localparam int VW = 1 + 1 + 2 + (CB + 1) + BW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led = 1'b0;
    logic flg = 1'b0;

    logic          lk0, er0, lk1, er1;
    logic [1:0]    ec0, ec1;
    logic [CB:0]   lp0, lp1;
    logic [BW-1:0] bk0, bk1;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    blink_checker #(.CBITS(CB), .TOL(0), .BW(BW)) dut0 (
        .clk(clk), .rst(rst), .led_in(led), .flg_in(flg),
        .locked(lk0), .err(er0), .err_code(ec0), .last_period(lp0), .blinks(bk0)
    );

    blink_checker #(.CBITS(CB), .TOL(1), .BW(BW)) dut1 (
        .clk(clk), .rst(rst), .led_in(led), .flg_in(flg),
        .locked(lk1), .err(er1), .err_code(ec1), .last_period(lp1), .blinks(bk1)
    );

    // Reference model: instance m has TOL=m; works from flg timestamps, not a gap counter.
    int            t;
    int            md [2];
    int            tf [2];
    bit            ll [2];
    logic          m_lk [2];
    logic          m_er [2];
    logic [1:0]    m_ec [2];
    logic [CB:0]   m_lp [2];
    logic [BW-1:0] m_bk [2];
    bit            lv;
    logic [VW-1:0] exp_v [2];

    function automatic logic [VW-1:0] pk(bit l, bit e, int c, int p, int b);
        return {l, e, 2'(c), (CB + 1)'(p), BW'(b)};
    endfunction

    function automatic logic [VW-1:0] obs(int m);
        if (m == 0) return {lk0, er0, ec0, lp0, bk0};
        return {lk1, er1, ec1, lp1, bk1};
    endfunction

    function automatic logic [VW-1:0] mvec(int m);
        return {m_lk[m], m_er[m], m_ec[m], m_lp[m], m_bk[m]};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            md[m] = 0; tf[m] = 0; ll[m] = 1'b0;
            m_lk[m] = 1'b0; m_er[m] = 1'b0; m_ec[m] = 2'd0; m_lp[m] = '0; m_bk[m] = '0;
        end
    endtask

    task automatic model_step(int m, bit f, bit l);
        int since, gap, dev, code;
        bit after, chg, e1;
        since = t - tf[m];
        gap   = (since > 2 * P - 1) ? 2 * P - 1 : since;
        if (md[m] == 0) begin
            if (f) begin md[m] = 1; tf[m] = t; end
        end else if (md[m] != 3) begin
            after = (since == 1);
            chg   = (l != ll[m]);
            dev   = (gap > P) ? gap - P : P - gap;
            e1    = f ? (dev > m) : (gap >= P + m + 1);
            code  = e1 ? 1 : (after && !chg) ? 2 : (!after && chg) ? 3 : 0;
            if (code != 0) begin
                md[m] = 3; m_er[m] = 1'b1; m_lk[m] = 1'b0; m_ec[m] = 2'(code);
                if (f) m_lp[m] = (CB + 1)'(gap);
            end else begin
                if (after) m_bk[m] = m_bk[m] + 1'b1;
                if (f) begin
                    md[m] = 2; m_lk[m] = 1'b1; m_lp[m] = (CB + 1)'(gap); tf[m] = t;
                end
            end
        end
        ll[m] = l;
    endtask

    task automatic tick(bit f, bit l);
        flg = f;
        led = l;
        @(posedge clk);
        t++;
        model_step(0, f, l);
        model_step(1, f, l);
        #1;
    endtask

    // n cycles after a flg: optional toggle on the first, optional flg on the last.
    task automatic run(int n, bit tog, bit endf);
        for (int i = 1; i <= n; i++) begin
            if (i == 1 && tog) lv = ~lv;
            tick(endf && (i == n), lv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; flg = 1'b0; led = 1'b0; lv = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flg = 1'b1; led = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(0, 0, 0, 0, 0)) begin
                nerr++; $display("FAIL reset dut%0d: got %h want %h", m, obs(m), pk(0, 0, 0, 0, 0));
            end
        end
        do_reset();
    endtask

    task automatic test_ideal();
        do_reset();
        run(3, 0, 0);
        tick(1, lv);
        run(15, 1, 0);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(0, 0, 0, 0, 1)) begin
                nerr++; $display("FAIL ideal_acq dut%0d: got %h want %h", m, obs(m), pk(0, 0, 0, 0, 1));
            end
        end
        tick(1, lv);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(1, 0, 0, 16, 1)) begin
                nerr++; $display("FAIL ideal_lock dut%0d: got %h want %h", m, obs(m), pk(1, 0, 0, 16, 1));
            end
        end
        repeat (3) run(16, 1, 1);
        run(1, 1, 0);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(1, 0, 0, 16, 5)) begin
                nerr++; $display("FAIL ideal_blinks dut%0d: got %h want %h", m, obs(m), pk(1, 0, 0, 16, 5));
            end
        end
    endtask

    task automatic test_early();
        run(14, 0, 1);
        exp_v[0] = pk(0, 1, 1, 15, 5);
        exp_v[1] = pk(1, 0, 0, 15, 5);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== exp_v[m]) begin
                nerr++; $display("FAIL early_flg dut%0d: got %h want %h", m, obs(m), exp_v[m]);
            end
        end
        run(3, 1, 0);
        exp_v[1] = pk(1, 0, 0, 15, 6);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== exp_v[m]) begin
                nerr++; $display("FAIL early_frozen dut%0d: got %h want %h", m, obs(m), exp_v[m]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        tick(1, lv);
        run(16, 1, 1);
        run(16, 1, 0);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(1, 0, 0, 16, 2)) begin
                nerr++; $display("FAIL timeout_before dut%0d: got %h want %h", m, obs(m), pk(1, 0, 0, 16, 2));
            end
        end
        tick(0, lv);
        exp_v[0] = pk(0, 1, 1, 16, 2);
        exp_v[1] = pk(1, 0, 0, 16, 2);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== exp_v[m]) begin
                nerr++; $display("FAIL timeout_17 dut%0d: got %h want %h", m, obs(m), exp_v[m]);
            end
        end
        tick(0, lv);
        nchk++;
        if (obs(1) !== pk(0, 1, 1, 16, 2)) begin
            nerr++; $display("FAIL timeout_18 dut1: got %h want %h", obs(1), pk(0, 1, 1, 16, 2));
        end
    endtask

    task automatic test_missing_toggle();
        do_reset();
        tick(1, lv);
        tick(0, lv);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(0, 1, 2, 0, 0)) begin
                nerr++; $display("FAIL missing_toggle dut%0d: got %h want %h", m, obs(m), pk(0, 1, 2, 0, 0));
            end
        end
        run(15, 0, 1);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(0, 1, 2, 0, 0)) begin
                nerr++; $display("FAIL missing_nolock dut%0d: got %h want %h", m, obs(m), pk(0, 1, 2, 0, 0));
            end
        end
        do_reset();
        tick(1, lv);
        run(15, 1, 1);
        exp_v[0] = pk(0, 1, 1, 15, 1);
        exp_v[1] = pk(1, 0, 0, 15, 1);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== exp_v[m]) begin
                nerr++; $display("FAIL tol_gap15 dut%0d: got %h want %h", m, obs(m), exp_v[m]);
            end
        end
        run(17, 1, 1);
        exp_v[1] = pk(1, 0, 0, 17, 2);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== exp_v[m]) begin
                nerr++; $display("FAIL tol_gap17 dut%0d: got %h want %h", m, obs(m), exp_v[m]);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        tick(1, lv);
        run(16, 1, 1);
        run(5, 1, 0);
        lv = ~lv;
        tick(0, lv);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(0, 1, 3, 16, 2)) begin
                nerr++; $display("FAIL glitch dut%0d: got %h want %h", m, obs(m), pk(0, 1, 3, 16, 2));
            end
        end
        do_reset();
        tick(1, lv);
        run(16, 1, 1);
        run(14, 1, 0);
        lv = ~lv;
        tick(1, lv);
        exp_v[0] = pk(0, 1, 1, 15, 2);
        exp_v[1] = pk(0, 1, 3, 15, 2);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== exp_v[m]) begin
                nerr++; $display("FAIL coincide dut%0d: got %h want %h", m, obs(m), exp_v[m]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(1, lv);
        run(1, 1, 1);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(0, 1, 1, 1, 0)) begin
                nerr++; $display("FAIL b2b_toggle dut%0d: got %h want %h", m, obs(m), pk(0, 1, 1, 1, 0));
            end
        end
        do_reset();
        tick(1, lv);
        tick(1, lv);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(0, 1, 1, 1, 0)) begin
                nerr++; $display("FAIL b2b_notoggle dut%0d: got %h want %h", m, obs(m), pk(0, 1, 1, 1, 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1, lv);
        repeat (6) run(16, 1, 1);
        run(1, 1, 0);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(1, 0, 0, 16, 7)) begin
                nerr++; $display("FAIL pre_rst dut%0d: got %h want %h", m, obs(m), pk(1, 0, 0, 16, 7));
            end
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(0, 0, 0, 0, 0)) begin
                nerr++; $display("FAIL async_rst dut%0d: got %h want %h", m, obs(m), pk(0, 0, 0, 0, 0));
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(0, lv);
        tick(1, lv);
        run(16, 1, 1);
        for (int m = 0; m < 2; m++) begin
            nchk++;
            if (obs(m) !== pk(1, 0, 0, 16, 1)) begin
                nerr++; $display("FAIL relock dut%0d: got %h want %h", m, obs(m), pk(1, 0, 0, 16, 1));
            end
        end
    endtask

    task automatic test_random();
        int gap, cnt;
        bit f;
        for (int r = 0; r < 30; r++) begin
            do_reset();
            repeat ($urandom_range(0, 4)) begin
                if ($urandom % 3 == 0) lv = ~lv;
                tick(0, lv);
            end
            tick(1, lv);
            cnt = 0;
            gap = 16;
            for (int c = 0; c < 120; c++) begin
                f = (cnt + 1 == gap);
                if (cnt == 0) begin
                    if ($urandom % 20 != 0) lv = ~lv;
                end else if ($urandom % 60 == 0) begin
                    lv = ~lv;
                end
                tick(f, lv);
                cnt = f ? 0 : cnt + 1;
                if (f) gap = ($urandom % 4 == 0) ? $urandom_range(1, 20) : 16;
                for (int m = 0; m < 2; m++) begin
                    nchk++;
                    if (obs(m) !== mvec(m)) begin
                        nerr++; $display("FAIL random r%0d c%0d dut%0d: got %h want %h", r, c, m, obs(m), mvec(m));
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t = 0;
        lv = 1'b0;
        model_reset();
        test_reset();
        test_ideal();
        test_early();
        test_timeout();
        test_missing_toggle();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
